// File: rtl/ir_a2d_seq.sv
// IR emitter / A2D sweep sequencer.
// Walks six result slots in three emitter pairs (inner, mid, outer). Each pair
// enables its IR emitter, waits SETTLE_CYC clocks, then converts the left and
// right receivers. Results are held in six slot registers that are readable
// combinationally through rd_sel.
// Optional build macro IR_SEQ_AVG_EN: each slot is converted twice and the
// stored value is the truncated mean of the two readings.
module ir_a2d_seq #(
  parameter int SETTLE_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic        busy,
  output logic        sweep_done,
  input  logic [2:0]  rd_sel,
  output logic [11:0] rd_data
);

  localparam int DATA_W = 12;
  localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, STORE} state_t;

  state_t             state;
  state_t             nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         slot;
  logic [DATA_W-1:0]  slot_q [6];
  logic               last_store;

`ifdef IR_SEQ_AVG_EN
  logic               second;
  logic [DATA_W-1:0]  first_res;
`endif

  // Receiver channel wired to each slot: inner L/R, mid L/R, outer L/R.
  function automatic logic [2:0] chan_of(input logic [2:0] s);
    case (s)
      3'd0:    chan_of = 3'd1;
      3'd1:    chan_of = 3'd0;
      3'd2:    chan_of = 3'd4;
      3'd3:    chan_of = 3'd2;
      3'd4:    chan_of = 3'd3;
      3'd5:    chan_of = 3'd7;
      default: chan_of = 3'd0;
    endcase
  endfunction

`ifdef IR_SEQ_AVG_EN
  // Mean of two readings; 13-bit sum so the carry is kept before the shift.
  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum  = {1'b0, a} + {1'b0, b};
    avg2 = sum[DATA_W:1];
  endfunction
`endif

  assign last_store = (state == STORE) && (slot == 3'd5);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    nxt       = state;
    strt_cnv  = 1'b0;
    chnnl     = 3'd0;
    IR_in_en  = 1'b0;
    IR_mid_en = 1'b0;
    IR_out_en = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:   if (go) nxt = SETTLE;
      SETTLE: if (cnt == SETTLE_LAST) nxt = CONV;
      CONV:   nxt = WAIT;
      WAIT: begin
        if (cnv_cmplt) begin
`ifdef IR_SEQ_AVG_EN
          nxt = second ? STORE : CONV;
`else
          nxt = STORE;
`endif
        end
      end
      STORE: begin
        if (slot == 3'd5)  nxt = IDLE;
        else if (!slot[0]) nxt = CONV;
        else               nxt = SETTLE;
      end
      default: nxt = IDLE;
    endcase
    if (state != IDLE) begin
      busy      = 1'b1;
      chnnl     = chan_of(slot);
      IR_in_en  = (slot[2:1] == 2'd0);
      IR_mid_en = (slot[2:1] == 2'd1);
      IR_out_en = (slot[2:1] == 2'd2);
    end
    strt_cnv = (state == CONV);
  end

  // Settle counter, slot index and end-of-sweep pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      slot       <= '0;
      sweep_done <= 1'b0;
`ifdef IR_SEQ_AVG_EN
      second     <= 1'b0;
`endif
    end else begin
      sweep_done <= last_store;
      if ((nxt == SETTLE) && (state != SETTLE)) cnt <= '0;
      else if (state == SETTLE)                 cnt <= cnt + 1'b1;
      if (state == STORE) slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
`ifdef IR_SEQ_AVG_EN
      if ((state == WAIT) && cnv_cmplt) second <= ~second;
`endif
    end
  end

  // Result slot registers, written only on a completion seen in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
    end else if ((state == WAIT) && cnv_cmplt) begin
`ifdef IR_SEQ_AVG_EN
      if (second) slot_q[slot] <= avg2(first_res, A2D_res);
`else
      slot_q[slot] <= A2D_res;
`endif
    end
  end

`ifdef IR_SEQ_AVG_EN
  // First reading of a slot, held until the second one arrives.
  always_ff @(posedge clk) begin
    if ((state == WAIT) && cnv_cmplt && !second) first_res <= A2D_res;
  end
`endif

  assign rd_data = (rd_sel < 3'd6) ? slot_q[rd_sel] : '0;

endmodule

// File: tb/tb_ir_a2d_seq.sv
// Self-checking bench for ir_a2d_seq with a bench-side A2D responder and a
// reference that derives slot contents from the list of completed conversions.
module tb_ir_a2d_seq;

  localparam int SETTLE = 16;
`ifdef IR_SEQ_AVG_EN
  localparam int PER = 2;
`else
  localparam int PER = 1;
`endif
  localparam int NCONV = 6 * PER;
  localparam int SEQ [6] = '{1, 0, 4, 2, 3, 7};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic        busy;
  logic        sweep_done;
  logic [2:0]  rd_sel;
  logic [11:0] rd_data;

  ir_a2d_seq #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_in_en(IR_in_en),
    .IR_mid_en(IR_mid_en), .IR_out_en(IR_out_en), .busy(busy),
    .sweep_done(sweep_done), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_miss = 0;
  int       cyc = 0;
  int       ir_rise, first_strt, n_done;
  logic     busy_at_done;
  logic     prev_in = 1'b0;
  int       q_ch [$];
  int       q_en [$];
  int       conv_ch [$];
  int       conv_val [$];
  bit       awaiting = 0, hold_resp = 0, spur_mode = 0, tog = 0;
  int       dly = 0, pend_ch = 0, mode = 0;
  int       exp_slot [6] = '{0, 0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Value the A2D model returns for one conversion of channel ch.
  function automatic int gen_val(input int ch);
    int v;
    case (mode)
      0:       v = 'h100 + ch;
      1:       v = int'($urandom_range(0, 4095));
      default: begin v = tog ? 'hFFE : 'hFFF; tog = ~tog; end
    endcase
    return v;
  endfunction

  // One clock: sample outputs after the edge, then drive the A2D model inputs.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    chk("rd_unused", 32'(rd_data), 32'h0);
    if (IR_in_en && !prev_in && ir_rise < 0) ir_rise = cyc;
    prev_in = IR_in_en;
    if (sweep_done) begin n_done++; busy_at_done = busy; end
    cnv_cmplt = 1'b0;
    A2D_res   = 12'($urandom);
    rd_sel    = 3'(6 + $urandom_range(0, 1));
    if (strt_cnv) begin
      q_ch.push_back(int'(chnnl));
      q_en.push_back(int'({IR_out_en, IR_mid_en, IR_in_en}));
      if (first_strt < 0) first_strt = cyc;
      pend_ch  = int'(chnnl);
      dly      = int'($urandom_range(1, 4));
      awaiting = 1;
    end else if (awaiting) begin
      if (!hold_resp) begin
        dly--;
        if (dly == 0) begin
          int v;
          v = gen_val(pend_ch);
          cnv_cmplt = 1'b1;
          A2D_res   = 12'(v);
          conv_ch.push_back(pend_ch);
          conv_val.push_back(v);
          awaiting = 0;
        end
      end
    end else if (spur_mode && $urandom_range(0, 3) == 0) begin
      cnv_cmplt = 1'b1;
      A2D_res   = 12'hFFF;
    end
  endtask

  task automatic clear_rec();
    q_ch.delete(); q_en.delete(); conv_ch.delete(); conv_val.delete();
    ir_rise = -1; first_strt = -1; n_done = 0; tog = 0; busy_at_done = 1'bx;
  endtask

  task automatic finish_sweep();
    int k = 0;
    while (n_done == 0 && k < 2000) begin step(); k++; end
    chk("sweep_end", 32'(n_done), 32'd1);
  endtask

  // Expected slot contents from the completed conversions, by channel.
  task automatic update_exp();
    for (int i = 0; i < 6; i++) begin
      int v [$];
      foreach (conv_ch[k]) if (conv_ch[k] == SEQ[i]) v.push_back(conv_val[k]);
      if (v.size() >= PER) begin
        if (PER == 2) exp_slot[i] = (v[v.size()-2] + v[v.size()-1]) / 2;
        else          exp_slot[i] = v[v.size()-1];
      end
    end
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < 6; i++) begin
      rd_sel = 3'(i); #1;
      chk({tag, "_slot", $sformatf("%0d", i)}, 32'(rd_data), 32'(exp_slot[i]));
    end
    rd_sel = 3'd6; #1; chk({tag, "_rd6"}, 32'(rd_data), 32'h0);
    rd_sel = 3'd7; #1; chk({tag, "_rd7"}, 32'(rd_data), 32'h0);
  endtask

  task automatic check_sweep(input string tag);
    chk({tag, "_settle_lat"}, 32'(first_strt - ir_rise), 32'(SETTLE));
    chk({tag, "_nstrt"}, 32'(q_ch.size()), 32'(NCONV));
    for (int k = 0; k < q_ch.size() && k < NCONV; k++) begin
      chk({tag, "_chnnl"}, 32'(q_ch[k]), 32'(SEQ[k / PER]));
      chk({tag, "_ir_en"}, 32'(q_en[k]), 32'(1 << (k / PER / 2)));
    end
    chk({tag, "_ndone"}, 32'(n_done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    update_exp();
    check_slots(tag);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; cnv_cmplt = 1'b0; A2D_res = 12'h0; rd_sel = 3'd6;
    clear_rec();
    step(); step();
    chk("reset_outs", 32'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, busy, sweep_done}), 32'h0);
    check_slots("reset");
    rst_n = 1'b1;
    step();

    // Sweep with fixed 0x100+channel readings (constant FFF/FFE pair when averaging).
    mode = (PER == 2) ? 2 : 0;
    clear_rec(); go = 1'b1; step(); go = 1'b0;
    finish_sweep();
    check_sweep("fixed");
`ifdef IR_SEQ_AVG_EN
    for (int i = 0; i < 6; i++) begin
      rd_sel = 3'(i); #1; chk("avg_ffe", 32'(rd_data), 32'hFFE);
    end
`else
    chk("fixed_slot0_lit", 32'(exp_slot[0]), 32'h101);
`endif

    // Random readings with spurious completions whenever none is expected.
    mode = 1; spur_mode = 1;
    clear_rec(); go = 1'b1; step(); go = 1'b0;
    finish_sweep();
    check_sweep("spur");
    spur_mode = 0;
    repeat (3) step();

    // go held through a sweep: one sweep, then a new one right out of IDLE.
    clear_rec(); go = 1'b1;
    begin
      int k = 0;
      while (n_done == 0 && k < 2000) begin step(); k++; end
    end
    chk("held_first_end", 32'(n_done), 32'd1);
    check_sweep("held1");
    step();
    chk("held_restart", 32'({busy, IR_in_en}), 32'h3);
    go = 1'b0;
    q_ch.delete(); q_en.delete(); conv_ch.delete(); conv_val.delete();
    ir_rise = cyc; first_strt = -1; n_done = 0; tog = 0;
    finish_sweep();
    check_sweep("held2");
    repeat (3) step();

    // Reset pulse while slot 3 is waiting on its conversion.
    clear_rec(); go = 1'b1; step(); go = 1'b0;
    begin
      int k = 0;
      while (q_ch.size() < 3 * PER + 1 && k < 2000) begin step(); k++; end
    end
    chk("rst_reach_slot3", 32'(q_ch.size()), 32'(3 * PER + 1));
    hold_resp = 1; step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_outs", 32'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, busy, sweep_done}), 32'h0);
    awaiting = 0; hold_resp = 0;
    for (int i = 0; i < 6; i++) exp_slot[i] = 0;
    check_slots("midrst");
    n_done = 0;
    repeat (20) step();
    chk("midrst_no_done", 32'(n_done), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    clear_rec(); go = 1'b1; step(); go = 1'b0;
    finish_sweep();
    check_sweep("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
